// File: rtl/button_pkg.sv
// Shared types and sizing helpers for the button conditioning front end.
package button_pkg;

  typedef enum logic [2:0] {
    RELEASED,
    PRESS_DEBOUNCE,
    HELD,
    LONG_HELD,
    RELEASE_DEBOUNCE
  } btn_state_t;

  function automatic int db_cnt_width(input int debounce_cycles);
    return $clog2(debounce_cycles + 1);
  endfunction

  function automatic int hold_cnt_width(input int long_press_cycles);
    return $clog2(long_press_cycles + 1);
  endfunction

endpackage

// File: rtl/sync_chain.sv
// N-stage flop synchroniser for an asynchronous single-bit input.
module sync_chain #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] stages;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stages <= '0;
    end else begin
      stages <= {stages[STAGES-2:0], d};
    end
  end

  assign q = stages[STAGES-1];

endmodule

// File: rtl/button_conditioner.sv
// Synchronises and debounces a raw button pin; emits a clean level plus
// single-cycle press, release and long-press strobes.
module button_conditioner
  import button_pkg::*;
#(
  parameter int SYNC_STAGES       = 2,
  parameter int DEBOUNCE_CYCLES   = 4,
  parameter int LONG_PRESS_CYCLES = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic button,
  output logic pressed,
  output logic press_pulse,
  output logic release_pulse,
  output logic long_press_pulse
);

  localparam int DW = db_cnt_width(DEBOUNCE_CYCLES);
  localparam int HW = hold_cnt_width(LONG_PRESS_CYCLES);
  localparam logic [DW-1:0] DB_MAX   = DW'(DEBOUNCE_CYCLES);
  localparam logic [HW-1:0] HOLD_MAX = HW'(LONG_PRESS_CYCLES);
  localparam bit DB_ONE = (DEBOUNCE_CYCLES == 1);

  if (SYNC_STAGES < 2 || SYNC_STAGES > 4) begin : g_bad_sync
    $error("button_conditioner: SYNC_STAGES must be 2..4");
  end
  if (DEBOUNCE_CYCLES < 1 || LONG_PRESS_CYCLES <= DEBOUNCE_CYCLES) begin : g_bad_counts
    $error("button_conditioner: need 1 <= DEBOUNCE_CYCLES < LONG_PRESS_CYCLES");
  end

  logic          sync_out;
  btn_state_t    state;
  logic [DW-1:0] db_cnt;
  logic [HW-1:0] hold_cnt;
  logic          from_long;
  logic [DW-1:0] db_inc;
  logic [HW-1:0] hold_inc;

  sync_chain #(.STAGES(SYNC_STAGES)) u_sync (
    .clk   (clk),
    .rst_n (reset),
    .d     (button),
    .q     (sync_out)
  );

  // Counters saturate; a level is accepted on the cycle the stable-sample
  // count reaches its threshold, so latency is SYNC_STAGES+DEBOUNCE_CYCLES.
  assign db_inc   = (db_cnt == DB_MAX)     ? DB_MAX   : db_cnt + DW'(1);
  assign hold_inc = (hold_cnt == HOLD_MAX) ? HOLD_MAX : hold_cnt + HW'(1);

  // NOTE: asynchronous reset clears every state flop; all sequential updates
  // use <= so later assignments in the same cycle override the strobe defaults.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state            <= RELEASED;
      db_cnt           <= '0;
      hold_cnt         <= '0;
      from_long        <= 1'b0;
      pressed          <= 1'b0;
      press_pulse      <= 1'b0;
      release_pulse    <= 1'b0;
      long_press_pulse <= 1'b0;
    end else begin
      press_pulse      <= 1'b0;
      release_pulse    <= 1'b0;
      long_press_pulse <= 1'b0;

      case (state)
        RELEASED: begin
          if (sync_out) begin
            if (DB_ONE) begin
              state       <= HELD;
              pressed     <= 1'b1;
              press_pulse <= 1'b1;
              hold_cnt    <= HW'(1);
              db_cnt      <= '0;
            end else begin
              state  <= PRESS_DEBOUNCE;
              db_cnt <= DW'(1);
            end
          end
        end

        PRESS_DEBOUNCE: begin
          if (!sync_out) begin
            state  <= RELEASED;
            db_cnt <= '0;
          end else if (db_inc == DB_MAX) begin
            state       <= HELD;
            pressed     <= 1'b1;
            press_pulse <= 1'b1;
            hold_cnt    <= HW'(1);
            db_cnt      <= '0;
          end else begin
            db_cnt <= db_inc;
          end
        end

        HELD: begin
          hold_cnt <= hold_inc;
          if (hold_inc == HOLD_MAX) begin
            // Long-press wins a tie with a falling input; release still debounces.
            long_press_pulse <= 1'b1;
            from_long        <= 1'b1;
            state            <= sync_out ? LONG_HELD : RELEASE_DEBOUNCE;
            if (!sync_out) db_cnt <= DW'(1);
          end else if (!sync_out) begin
            from_long <= 1'b0;
            if (DB_ONE) begin
              state         <= RELEASED;
              pressed       <= 1'b0;
              release_pulse <= 1'b1;
            end else begin
              state  <= RELEASE_DEBOUNCE;
              db_cnt <= DW'(1);
            end
          end
        end

        LONG_HELD: begin
          if (!sync_out) begin
            from_long <= 1'b1;
            if (DB_ONE) begin
              state         <= RELEASED;
              pressed       <= 1'b0;
              release_pulse <= 1'b1;
            end else begin
              state  <= RELEASE_DEBOUNCE;
              db_cnt <= DW'(1);
            end
          end
        end

        RELEASE_DEBOUNCE: begin
          if (sync_out) begin
            state  <= from_long ? LONG_HELD : HELD;
            db_cnt <= '0;
          end else if (db_inc == DB_MAX) begin
            state         <= RELEASED;
            pressed       <= 1'b0;
            release_pulse <= 1'b1;
            db_cnt        <= '0;
          end else begin
            db_cnt <= db_inc;
          end
        end

        default: state <= RELEASED;
      endcase
    end
  end

endmodule

// File: tb/tb_button_conditioner.sv
// Self-checking bench: per-cycle scoreboard against a run-length model,
// a table of press patterns, reset corner cases and a random bounce soak.
module tb_button_conditioner;

  localparam int SYNC_STAGES       = 2;
  localparam int DEBOUNCE_CYCLES   = 4;
  localparam int LONG_PRESS_CYCLES = 16;
  localparam int OBS               = 50;
  localparam int NROWS             = 7;

  logic clk    = 1'b0;
  logic reset  = 1'b0;
  logic button = 1'b0;
  logic pressed, press_pulse, release_pulse, long_press_pulse;

  always #5 clk = ~clk;

  button_conditioner #(
    .SYNC_STAGES       (SYNC_STAGES),
    .DEBOUNCE_CYCLES   (DEBOUNCE_CYCLES),
    .LONG_PRESS_CYCLES (LONG_PRESS_CYCLES)
  ) dut (
    .clk              (clk),
    .reset            (reset),
    .button           (button),
    .pressed          (pressed),
    .press_pulse      (press_pulse),
    .release_pulse    (release_pulse),
    .long_press_pulse (long_press_pulse)
  );

  typedef struct packed {
    logic pressed;
    logic press;
    logic rel;
    logic lng;
  } exp_t;

  typedef struct {
    string       name;
    logic [63:0] pattern;
    int          len;
    logic        tail;
    int          press_edge;
    int          long_edge;
    int          release_edge;
    int          n_press;
    int          n_long;
    int          n_release;
  } vec_t;

  typedef enum {K_NONE, K_PRESS, K_RELEASE} kind_t;

  exp_t  sb[$];
  int    n_cmp = 0;
  int    n_bad = 0;

  // Model state: delay line plus run length of samples disagreeing with the level.
  logic  m_sync [SYNC_STAGES];
  logic  m_pressed;
  int    m_run;
  int    m_hold;
  logic  m_long_done;

  // Observation state for the current run.
  int    edge_no;
  int    n_press, n_long, n_release;
  int    first_press, first_long, first_release;
  kind_t last_kind;
  logic  prev_pulse;

  vec_t  rows [NROWS];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic model_clear();
    for (int i = 0; i < SYNC_STAGES; i++) m_sync[i] = 1'b0;
    m_pressed     = 1'b0;
    m_run         = 0;
    m_hold        = 0;
    m_long_done   = 1'b0;
    edge_no       = 0;
    n_press       = 0;
    n_long        = 0;
    n_release     = 0;
    first_press   = 0;
    first_long    = 0;
    first_release = 0;
    last_kind     = K_NONE;
    prev_pulse    = 1'b0;
    sb.delete();
  endtask

  // Predicts the outputs visible after the coming rising edge.
  task automatic model_edge(input logic b, output exp_t e);
    logic seen;
    int   run_before;
    e    = '0;
    seen = m_sync[SYNC_STAGES-1];
    for (int i = SYNC_STAGES - 1; i > 0; i--) m_sync[i] = m_sync[i-1];
    m_sync[0]  = b;
    run_before = m_run;
    if (m_pressed && run_before == 0 && !m_long_done) begin
      m_hold++;
      if (m_hold == LONG_PRESS_CYCLES) begin
        e.lng       = 1'b1;
        m_long_done = 1'b1;
      end
    end
    if (seen != m_pressed) m_run++;
    else m_run = 0;
    if (m_run == DEBOUNCE_CYCLES) begin
      m_pressed = !m_pressed;
      m_run     = 0;
      if (m_pressed) begin
        e.press     = 1'b1;
        m_hold      = 1;
        m_long_done = 1'b0;
      end else begin
        e.rel = 1'b1;
      end
    end
    e.pressed = m_pressed;
  endtask

  task automatic check_out();
    exp_t e, act;
    logic any;
    act = {pressed, press_pulse, release_pulse, long_press_pulse};
    edge_no++;
    if (sb.size() == 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL scoreboard_empty: got no expectation at edge %0d", edge_no);
      return;
    end
    e = sb.pop_front();
    check($sformatf("outputs_edge%0d", edge_no), act, e);
    any = act.press | act.rel | act.lng;
    if (any) begin
      check("pulse_gap", prev_pulse, 1'b0);
      check("pulse_onehot", $countones({act.press, act.rel, act.lng}), 1);
    end
    if (act.press) begin
      n_press++;
      if (first_press == 0) first_press = edge_no;
      check("press_alternates", last_kind == K_PRESS, 1'b0);
      last_kind = K_PRESS;
    end
    if (act.rel) begin
      n_release++;
      if (first_release == 0) first_release = edge_no;
      check("release_alternates", last_kind == K_PRESS, 1'b1);
      last_kind = K_RELEASE;
    end
    if (act.lng) begin
      n_long++;
      if (first_long == 0) first_long = edge_no;
      check("long_inside_press", last_kind == K_PRESS, 1'b1);
    end
    prev_pulse = any;
  endtask

  // Drive one cycle of stimulus shortly after an edge, then sample after the next.
  task automatic step(input logic b);
    exp_t e;
    button = b;
    model_edge(b, e);
    sb.push_back(e);
    @(posedge clk);
    #1;
    check_out();
  endtask

  task automatic apply_reset();
    reset  = 1'b0;
    button = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_outputs", {pressed, press_pulse, release_pulse, long_press_pulse}, 4'b0);
    model_clear();
    reset = 1'b1;
  endtask

  task automatic reset_mid(input int n_before, input string tag);
    apply_reset();
    for (int i = 0; i < n_before; i++) step(1'b1);
    #2 reset = 1'b0;
    #1 check({tag, "_async_clear"}, {pressed, press_pulse, release_pulse, long_press_pulse}, 4'b0);
    repeat (3) @(posedge clk);
    #1;
    model_clear();
    reset = 1'b1;
    for (int i = 0; i < 8; i++) step(1'b1);
    check({tag, "_press_edge"}, first_press, 6);
    check({tag, "_press_count"}, n_press, 1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "bench timeout");
  end

  initial begin
    logic v;
    int   len;
    int   cyc;

    //            name            pattern             len tail press long rel  #p #l #r
    rows[0] = '{"single_cycle",  64'h1,               1, 1'b0, 0,    0,   0,   0, 0, 0};
    rows[1] = '{"held_30",       64'h3FFF_FFFF,       30, 1'b0, 6,    21,  36,  1, 1, 1};
    rows[2] = '{"bounce_3_1_10", 64'h3FF7,            14, 1'b1, 10,   25,  0,   1, 1, 0};
    rows[3] = '{"glitch_3",      64'h7,               3, 1'b0, 0,    0,   0,   0, 0, 0};
    rows[4] = '{"exact_4",       64'hF,               4, 1'b0, 6,    0,   10,  1, 0, 1};
    rows[5] = '{"held_glitch",   64'hF_F3FF,          20, 1'b0, 6,    23,  26,  1, 1, 1};
    rows[6] = '{"long_glitch",   64'h7_F9FF_FFFF,     35, 1'b0, 6,    21,  41,  1, 1, 1};

    for (int r = 0; r < NROWS; r++) begin
      apply_reset();
      for (int i = 0; i < OBS; i++) begin
        step(i < rows[r].len ? rows[r].pattern[i] : rows[r].tail);
      end
      check({rows[r].name, "_press_edge"},   first_press,   rows[r].press_edge);
      check({rows[r].name, "_long_edge"},    first_long,    rows[r].long_edge);
      check({rows[r].name, "_release_edge"}, first_release, rows[r].release_edge);
      check({rows[r].name, "_n_press"},      n_press,       rows[r].n_press);
      check({rows[r].name, "_n_long"},       n_long,        rows[r].n_long);
      check({rows[r].name, "_n_release"},    n_release,     rows[r].n_release);
    end

    reset_mid(4, "rst_in_debounce");
    reset_mid(10, "rst_in_held");

    apply_reset();
    cyc = 0;
    while (cyc < 10000) begin
      v   = 1'($urandom_range(0, 1));
      len = ($urandom_range(0, 3) == 0) ? $urandom_range(20, 40) : $urandom_range(1, 6);
      for (int i = 0; i < len; i++) step(v);
      cyc += len;
    end
    for (int i = 0; i < 12; i++) step(1'b0);
    check("soak_saw_press", n_press > 0, 1'b1);
    check("soak_saw_long", n_long > 0, 1'b1);
    check("soak_balanced", n_press, n_release);
    check("soak_scoreboard_drained", sb.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/button_conditioner.md
Name: button_conditioner

Overview:
- Front-end stage between the raw asynchronous `button` pin and the RGB controller's button input.
- Synchronises the pin, debounces it, and emits a clean level plus single-cycle press, release and long-press events.
- The controller consumes `press_pulse` where it previously took the raw pin, so one physical press advances it exactly once.

Parameters:
- SYNC_STAGES, 2, number of synchronizer flops; legal range 2 to 4.
- DEBOUNCE_CYCLES, 4, consecutive stable cycles required to accept a level change; must be at least 1.
- LONG_PRESS_CYCLES, 16, cycles `pressed` must stay high before `long_press_pulse` fires; must be greater than DEBOUNCE_CYCLES.

Ports:
- clk  input  1  single system clock, rising edge.
- reset  input  1  asynchronous, active-low reset; 0 = in reset.
- button  input  1  raw, asynchronous, possibly bouncing pin; 1 = pressed.
- pressed  output  1  debounced button level.
- press_pulse  output  1  one-cycle strobe on each accepted 0->1 transition of `pressed`.
- release_pulse  output  1  one-cycle strobe on each accepted 1->0 transition of `pressed`.
- long_press_pulse  output  1  one-cycle strobe, at most once per press, when the hold reaches LONG_PRESS_CYCLES.

Behaviour:
- Reset: asserting reset=0 clears all outputs, synchronizer flops, counters and FSM (state RELEASED) asynchronously. Deassertion is synchronous to clk.
- Synchronizer: `sync_out` is the last of SYNC_STAGES flops. `button` reaches `sync_out` after SYNC_STAGES rising edges.
- FSM states: RELEASED, PRESS_DEBOUNCE, HELD, LONG_HELD, RELEASE_DEBOUNCE.
  - RELEASED: if sync_out=1, go to PRESS_DEBOUNCE and set db_cnt=1.
  - PRESS_DEBOUNCE:
    - sync_out=0: return to RELEASED, clear db_cnt, no pulse.
    - sync_out=1 and db_cnt=DEBOUNCE_CYCLES: go to HELD, set pressed=1, assert press_pulse for that cycle, set hold_cnt=1.
    - otherwise db_cnt++.
  - HELD: hold_cnt++ each cycle.
    - hold_cnt=LONG_PRESS_CYCLES: go to LONG_HELD and assert long_press_pulse for one cycle.
    - sync_out=0: go to RELEASE_DEBOUNCE with db_cnt=1.
  - LONG_HELD: hold_cnt does not count; no further long pulses. sync_out=0 goes to RELEASE_DEBOUNCE with db_cnt=1.
  - RELEASE_DEBOUNCE:
    - sync_out=1: return to the state it came from (HELD or LONG_HELD, kept in a 1-bit flag), clear db_cnt.
    - sync_out=0 and db_cnt=DEBOUNCE_CYCLES: go to RELEASED, set pressed=0, assert release_pulse.
    - otherwise db_cnt++.
    - hold_cnt is frozen (not cleared) while in this state.
- Latency: counting the edge that first samples button=1 as edge 1, `pressed` and `press_pulse` rise after edge SYNC_STAGES+DEBOUNCE_CYCLES. The same holds for release.
- Long-press timing: `long_press_pulse` rises LONG_PRESS_CYCLES-1 edges after `press_pulse`, provided there was no accepted release in between.
- Simultaneous events: if the long-press threshold and a sync_out falling edge occur in the same cycle, the long pulse fires and the FSM moves to RELEASE_DEBOUNCE.
- Pulse exclusivity: press_pulse, release_pulse and long_press_pulse are mutually exclusive. Each is high for exactly one cycle.
- Glitch rejection: a bounce shorter than DEBOUNCE_CYCLES cycles at sync_out produces no output change.
- Reset held low with button=1: after release, the block starts in RELEASED and a full press is reported.
- Counter widths: $clog2(LONG_PRESS_CYCLES+1) for hold_cnt and $clog2(DEBOUNCE_CYCLES+1) for db_cnt. Both saturate and never wrap.
- Outputs are registered; no combinational path from `button` to any output.

Decomposition:
- Package `button_pkg`:
  - enum `btn_state_t` (the five states).
  - functions for counter-width calculation.
- Sub-module `sync_chain`:
  - Parameterised N-stage flop synchroniser with the same asynchronous active-low reset.
  - Instantiated once; reused for other asynchronous pins.

Test Plan:
- Defaults, button high for 1 cycle only (edge after reset release): pressed stays 0 and no pulses, for 20 cycles.
- Defaults, button held 30 cycles from edge 1: press_pulse high after edge 6; long_press_pulse 15 edges later (after edge 21); exactly one of each.
- Defaults, button 1 for 3 cycles, 0 for 1 cycle, 1 for 10 cycles: one press_pulse, timed from the start of the final stable run; no release_pulse.
- Release bounce while in LONG_HELD, with a 2-cycle low glitch: no release_pulse; pressed stays 1; no second long_press_pulse.
- Reset asserted (reset=0) mid PRESS_DEBOUNCE and mid HELD: all outputs 0 immediately (asynchronously). With button still 1 after release, press_pulse appears after 6 edges.
- Random bounce soak, 10k cycles, with a scoreboard model: press_pulse and release_pulse alternate strictly; pulses are never adjacent; long_press_pulse appears only between press_pulse and release_pulse.
